// File: rtl/sid_bus_frontend.sv
// SID-style bus front end: samples the asynchronous 6502-style bus into sys_clk,
// emits clk_en/wr_strobe pulses and latched write data, plus power-on and warm-boot control.
// Optional macro SID_READBACK_EN enables driving rd_data back onto data_pad during reads.
module sid_bus_frontend #(
  parameter int POR_BITS = 16
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       phi2,
  input  logic       cs_n,
  input  logic       rw,
  input  logic [4:0] addr,
  inout  wire  [7:0] data_pad,
  input  logic [7:0] rd_data,
  input  logic       bootloader_req,
  output logic       clk_en,
  output logic       wr_strobe,
  output logic [4:0] bus_addr,
  output logic [7:0] bus_data,
  output logic       por_rst,
  output logic       boot
);

  logic                r_phi2_q;
  logic                r_cs_n_q;
  logic                r_rw_q;
  logic [4:0]          r_addr_q;
  logic [7:0]          r_data_q;
  logic                r_phi2_prev;
  logic                r_clk_en;
  logic                r_wr_strobe;
  logic [4:0]          r_bus_addr;
  logic [7:0]          r_bus_data;
  logic [POR_BITS-1:0] r_por_cnt;
  logic                r_por_rst;
  logic                r_boot;

  logic                w_fall;
  logic                w_wr;

  assign w_fall = r_phi2_prev & ~r_phi2_q;
  assign w_wr   = w_fall & ~r_cs_n_q & ~r_rw_q & ~r_por_rst;

  // Input stage: every pad signal passes through exactly one register before use.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phi2_q    <= 1'b0;
      r_cs_n_q    <= 1'b0;
      r_rw_q      <= 1'b0;
      r_addr_q    <= '0;
      r_data_q    <= '0;
      r_phi2_prev <= 1'b0;
    end else begin
      r_phi2_q    <= phi2;
      r_cs_n_q    <= cs_n;
      r_rw_q      <= rw;
      r_addr_q    <= addr;
      r_data_q    <= data_pad;
      r_phi2_prev <= r_phi2_q;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_en    <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_data  <= '0;
    end else begin
      r_clk_en    <= w_fall & ~r_por_rst;
      r_wr_strobe <= w_wr;
      if (w_wr) begin
        r_bus_addr <= r_addr_q;
        r_bus_data <= r_data_q;
      end
    end
  end

  // Counter saturates once its top bit sets; por_rst follows that bit one cycle later.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_por_cnt <= '0;
      r_por_rst <= 1'b1;
      r_boot    <= 1'b0;
    end else begin
      if (!r_por_cnt[POR_BITS-1])
        r_por_cnt <= r_por_cnt + 1'b1;
      r_por_rst <= ~r_por_cnt[POR_BITS-1];
      r_boot    <= r_boot | bootloader_req;
    end
  end

`ifdef SID_READBACK_EN
  logic       r_rd_oe;
  logic [7:0] r_rd_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_oe <= 1'b0;
      r_rd_q  <= '0;
    end else begin
      r_rd_oe <= r_phi2_q & ~r_cs_n_q & r_rw_q & ~r_por_rst;
      r_rd_q  <= rd_data;
    end
  end

  assign data_pad = r_rd_oe ? r_rd_q : 8'bz;
`else
  logic w_unused_rd;

  assign w_unused_rd = ^rd_data;
  assign data_pad    = 8'bz;
`endif

  assign clk_en    = r_clk_en;
  assign wr_strobe = r_wr_strobe;
  assign bus_addr  = r_bus_addr;
  assign bus_data  = r_bus_data;
  assign por_rst   = r_por_rst;
  assign boot      = r_boot;

endmodule

// File: tb/tb_sid_bus_frontend.sv
// Directed bench for sid_bus_frontend with POR_BITS=4; inputs change 1ns after a
// rising edge and outputs are sampled at that same point.
module tb_sid_bus_frontend;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       phi2;
  logic       cs_n;
  logic       rw;
  logic [4:0] addr;
  wire  [7:0] data_pad;
  logic [7:0] rd_data;
  logic       bootloader_req;
  logic       clk_en;
  logic       wr_strobe;
  logic [4:0] bus_addr;
  logic [7:0] bus_data;
  logic       por_rst;
  logic       boot;

  logic       tb_drv_en;
  logic [7:0] tb_drv;

  int vectors     = 0;
  int miscompares = 0;
  int por_high;

  assign data_pad = tb_drv_en ? tb_drv : 8'bz;

  always #5 sys_clk = ~sys_clk;

  sid_bus_frontend #(.POR_BITS(4)) dut (
    .sys_clk        (sys_clk),
    .rst_n          (rst_n),
    .phi2           (phi2),
    .cs_n           (cs_n),
    .rw             (rw),
    .addr           (addr),
    .data_pad       (data_pad),
    .rd_data        (rd_data),
    .bootloader_req (bootloader_req),
    .clk_en         (clk_en),
    .wr_strobe      (wr_strobe),
    .bus_addr       (bus_addr),
    .bus_data       (bus_data),
    .por_rst        (por_rst),
    .boot           (boot)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; phi2 = 1'b0; cs_n = 1'b1; rw = 1'b1; addr = '0;
    rd_data = 8'hA5; bootloader_req = 1'b0; tb_drv_en = 1'b1; tb_drv = 8'h00;
    #12;
    check("rst_por_rst", {7'd0, por_rst}, 8'd1);
    check("rst_clk_en", {7'd0, clk_en}, 8'd0);
    check("rst_wr_strobe", {7'd0, wr_strobe}, 8'd0);
    check("rst_bus_addr", {3'd0, bus_addr}, 8'h00);
    check("rst_bus_data", bus_data, 8'h00);
    check("rst_boot", {7'd0, boot}, 8'd0);

    // Power-on: count edges after release at which por_rst is still high.
    rst_n = 1'b1;
    por_high = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (por_rst) por_high++;
    end
    check("por_high_cycles", 8'(por_high), 8'd8);
    check("por_released", {7'd0, por_rst}, 8'd0);

    // Write cycle.
    phi2 = 1'b1; cs_n = 1'b0; rw = 1'b0; addr = 5'h18; tb_drv = 8'h0F;
    tick(); tick();
    phi2 = 1'b0;
    tick();
    check("wr_clk_en_early", {7'd0, clk_en}, 8'd0);
    tick();
    check("wr_clk_en", {7'd0, clk_en}, 8'd1);
    check("wr_strobe", {7'd0, wr_strobe}, 8'd1);
    check("wr_bus_addr", {3'd0, bus_addr}, 8'h18);
    check("wr_bus_data", bus_data, 8'h0F);
    cs_n = 1'b1; addr = 5'h03; tb_drv = 8'hAA;
    tick();
    check("wr_clk_en_end", {7'd0, clk_en}, 8'd0);
    check("wr_strobe_end", {7'd0, wr_strobe}, 8'd0);
    check("wr_hold_addr", {3'd0, bus_addr}, 8'h18);
    check("wr_hold_data", bus_data, 8'h0F);

    // Deselected write.
    phi2 = 1'b1; rw = 1'b0;
    tick(); tick();
    phi2 = 1'b0;
    tick(); tick();
    check("desel_clk_en", {7'd0, clk_en}, 8'd1);
    check("desel_wr_strobe", {7'd0, wr_strobe}, 8'd0);
    check("desel_bus_addr", {3'd0, bus_addr}, 8'h18);
    check("desel_bus_data", bus_data, 8'h0F);

    // Selected read, with a single-sample phi2 high (no glitch filter).
    cs_n = 1'b0; rw = 1'b1; addr = 5'h05; tb_drv = 8'h77;
    tick();
    phi2 = 1'b1;
    tick();
    phi2 = 1'b0;
    tick(); tick();
    check("rd_clk_en", {7'd0, clk_en}, 8'd1);
    check("rd_wr_strobe", {7'd0, wr_strobe}, 8'd0);
    check("rd_bus_addr", {3'd0, bus_addr}, 8'h18);
    check("rd_bus_data", bus_data, 8'h0F);

    // Readback path.
    phi2 = 1'b1; cs_n = 1'b0; rw = 1'b1; rd_data = 8'hA5;
`ifdef SID_READBACK_EN
    tb_drv_en = 1'b0;
    tick(); tick(); tick();
    check("readback_drive", data_pad, 8'hA5);
    phi2 = 1'b0;
    tick(); tick(); tick();
    tb_drv_en = 1'b1; tb_drv = 8'h3C;
    #1;
    check("readback_release", data_pad, 8'h3C);
`else
    tb_drv = 8'h3C;
    tick(); tick(); tick();
    check("readback_hiz", data_pad, 8'h3C);
    phi2 = 1'b0;
    tick(); tick(); tick();
`endif

    // Warm boot.
    cs_n = 1'b1; bootloader_req = 1'b1;
    tick();
    bootloader_req = 1'b0;
    check("boot_set", {7'd0, boot}, 8'd1);
    tick(); tick(); tick();
    check("boot_sticky", {7'd0, boot}, 8'd1);
    rst_n = 1'b0;
    #1;
    check("boot_cleared", {7'd0, boot}, 8'd0);
    check("rst2_por_rst", {7'd0, por_rst}, 8'd1);
    check("rst2_bus_addr", {3'd0, bus_addr}, 8'h00);

    // Write attempt while por_rst is still high must be suppressed.
    tick();
    rst_n = 1'b1;
    phi2 = 1'b1; cs_n = 1'b0; rw = 1'b0; addr = 5'h07; tb_drv = 8'h55;
    tick(); tick();
    phi2 = 1'b0;
    tick(); tick();
    check("sup_por_rst", {7'd0, por_rst}, 8'd1);
    check("sup_clk_en", {7'd0, clk_en}, 8'd0);
    check("sup_wr_strobe", {7'd0, wr_strobe}, 8'd0);
    check("sup_bus_addr", {3'd0, bus_addr}, 8'h00);
    check("sup_bus_data", bus_data, 8'h00);
    cs_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("por_released2", {7'd0, por_rst}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
